// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles every signal of the memory-access stage except clock and reset:
//   - execute-stage side : ex_valid/ex_ready handshake, ex_* operands, control bits
//   - branch resolution  : pc_src, branch_target
//   - data memory side   : dmem_req/we/addr/wdata out, dmem_ack/rdata in
//   - write-back record  : wb_valid, wb_reg_write, wb_rd, wb_data
//   - sticky error flags : err_misalign, err_illegal, err_timeout
// Modports:
//   slave  - the memory-access stage itself
//   master - its environment (execute stage, data memory, write-back consumer)
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_result;
    logic [63:0] ex_data2;
    logic        ex_zero;
    logic [63:0] ex_branch_addr;
    logic [4:0]  ex_rd;
    logic        B;
    logic        BZ;
    logic        BNZ;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        err_misalign;
    logic        err_illegal;
    logic        err_timeout;

    modport slave (
        input  ex_valid, ex_result, ex_data2, ex_zero, ex_branch_addr, ex_rd,
        input  B, BZ, BNZ, MemRead, MemWrite, MemtoReg, RegWrite,
        input  dmem_ack, dmem_rdata,
        output ex_ready, pc_src, branch_target,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_reg_write, wb_rd, wb_data,
        output err_misalign, err_illegal, err_timeout
    );

    modport master (
        output ex_valid, ex_result, ex_data2, ex_zero, ex_branch_addr, ex_rd,
        output B, BZ, BNZ, MemRead, MemWrite, MemtoReg, RegWrite,
        output dmem_ack, dmem_rdata,
        input  ex_ready, pc_src, branch_target,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_reg_write, wb_rd, wb_data,
        input  err_misalign, err_illegal, err_timeout
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage of the 64-bit LEGv8 core, directly after execute.
// Accepts one instruction per transfer (ex_valid & ex_ready), resolves
// B/CBZ/CBNZ into a one-cycle pc_src pulse, performs LDUR/STUR over a
// req/ack data-memory handshake and emits one write-back record per
// accepted instruction. While an access is outstanding ex_ready is low.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_access_stage_if.slave (execute, branch, dmem, wb, errors)
// Parameters:
//   TIMEOUT - cycles a request may stay unacknowledged before abort (>=2)
//   CNT_W   - width of the wait counter, must hold TIMEOUT
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_stage_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // The counter holds the number of unacknowledged request cycles already
    // elapsed; the last allowed cycle is the one where it equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    function automatic logic addr_aligned(input logic [63:0] addr);
        return (addr[2:0] == 3'b000);
    endfunction

    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;

    logic transfer_s;
    logic is_branch_s;
    logic illegal_s;
    logic mem_op_s;
    logic misalign_s;
    logic start_s;
    logic taken_s;
    logic ack_done_s;
    logic expire_s;

    logic        pc_src_r,        pc_src_nxt;
    logic [63:0] branch_target_r, branch_target_nxt;
    logic        dmem_req_r,      dmem_req_nxt;
    logic        dmem_we_r,       dmem_we_nxt;
    logic [63:0] dmem_addr_r,     dmem_addr_nxt;
    logic [63:0] dmem_wdata_r,    dmem_wdata_nxt;
    logic        wb_valid_r,      wb_valid_nxt;
    logic        wb_reg_write_r,  wb_reg_write_nxt;
    logic [4:0]  wb_rd_r,         wb_rd_nxt;
    logic [63:0] wb_data_r,       wb_data_nxt;
    logic        err_misalign_r,  err_misalign_nxt;
    logic        err_illegal_r,   err_illegal_nxt;
    logic        err_timeout_r,   err_timeout_nxt;
    logic [4:0]  pend_rd_r,       pend_rd_nxt;
    logic        pend_wen_r,      pend_wen_nxt;
    logic        pend_m2r_r,      pend_m2r_nxt;

    // Instruction classification of the operands presented by execute.
    always_comb begin
        transfer_s  = bus.ex_valid & (state_r == ST_IDLE);
        is_branch_s = bus.B | bus.BZ | bus.BNZ;
        taken_s     = bus.B | (bus.BZ & bus.ex_zero) | (bus.BNZ & ~bus.ex_zero);
        // Branches never touch memory, whatever the memory control bits say.
        illegal_s   = ~is_branch_s & bus.MemRead & bus.MemWrite;
        mem_op_s    = ~is_branch_s & (bus.MemRead ^ bus.MemWrite);
        misalign_s  = mem_op_s & ~addr_aligned(bus.ex_result);
        start_s     = mem_op_s & addr_aligned(bus.ex_result);
    end

    // FSM next state and wait counter; an ack in the expiry cycle wins.
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        ack_done_s = 1'b0;
        expire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (transfer_s && start_s) begin
                    state_nxt = ST_ACCESS;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.dmem_ack) begin
                    ack_done_s = 1'b1;
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s   = 1'b1;
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = CNT_ZERO;
                end else begin
                    state_nxt  = ST_ACCESS;
                    cnt_nxt    = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // Next values of the output and pending-instruction registers.
    always_comb begin
        pc_src_nxt        = 1'b0;
        branch_target_nxt = branch_target_r;
        // The request is high exactly while the FSM sits in ACCESS.
        dmem_req_nxt      = (state_nxt == ST_ACCESS);
        dmem_we_nxt       = dmem_we_r;
        dmem_addr_nxt     = dmem_addr_r;
        dmem_wdata_nxt    = dmem_wdata_r;
        wb_valid_nxt      = 1'b0;
        wb_reg_write_nxt  = 1'b0;
        wb_rd_nxt         = wb_rd_r;
        wb_data_nxt       = wb_data_r;
        err_misalign_nxt  = err_misalign_r;
        err_illegal_nxt   = err_illegal_r;
        err_timeout_nxt   = err_timeout_r;
        pend_rd_nxt       = pend_rd_r;
        pend_wen_nxt      = pend_wen_r;
        pend_m2r_nxt      = pend_m2r_r;

        if (transfer_s) begin
            pc_src_nxt = taken_s;
            if (taken_s) begin
                branch_target_nxt = bus.ex_branch_addr;
            end else begin
                branch_target_nxt = branch_target_r;
            end
            if (start_s) begin
                // Launch the access; remember what write-back will need.
                dmem_we_nxt    = bus.MemWrite;
                dmem_addr_nxt  = bus.ex_result;
                dmem_wdata_nxt = bus.ex_data2;
                pend_rd_nxt    = bus.ex_rd;
                pend_wen_nxt   = bus.RegWrite & bus.MemRead;
                pend_m2r_nxt   = bus.MemtoReg;
            end else begin
                // Non-memory op or rejected memory op: write back next cycle.
                wb_valid_nxt     = 1'b1;
                wb_rd_nxt        = bus.ex_rd;
                wb_data_nxt      = bus.ex_result;
                wb_reg_write_nxt = bus.RegWrite & ~(illegal_s | misalign_s);
                err_illegal_nxt  = err_illegal_r | illegal_s;
                err_misalign_nxt = err_misalign_r | misalign_s;
            end
        end else if (ack_done_s) begin
            wb_valid_nxt     = 1'b1;
            wb_rd_nxt        = pend_rd_r;
            wb_reg_write_nxt = pend_wen_r;
            if (pend_m2r_r) begin
                wb_data_nxt = bus.dmem_rdata;
            end else begin
                wb_data_nxt = dmem_addr_r;
            end
        end else if (expire_s) begin
            wb_valid_nxt     = 1'b1;
            wb_rd_nxt        = pend_rd_r;
            wb_reg_write_nxt = 1'b0;
            wb_data_nxt      = dmem_addr_r;
            err_timeout_nxt  = 1'b1;
        end else begin
            wb_valid_nxt = 1'b0;
        end
    end

    // Output and pending-instruction registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_src_r        <= 1'b0;
            branch_target_r <= 64'd0;
            dmem_req_r      <= 1'b0;
            dmem_we_r       <= 1'b0;
            dmem_addr_r     <= 64'd0;
            dmem_wdata_r    <= 64'd0;
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_data_r       <= 64'd0;
            err_misalign_r  <= 1'b0;
            err_illegal_r   <= 1'b0;
            err_timeout_r   <= 1'b0;
            pend_rd_r       <= 5'd0;
            pend_wen_r      <= 1'b0;
            pend_m2r_r      <= 1'b0;
        end else begin
            pc_src_r        <= pc_src_nxt;
            branch_target_r <= branch_target_nxt;
            dmem_req_r      <= dmem_req_nxt;
            dmem_we_r       <= dmem_we_nxt;
            dmem_addr_r     <= dmem_addr_nxt;
            dmem_wdata_r    <= dmem_wdata_nxt;
            wb_valid_r      <= wb_valid_nxt;
            wb_reg_write_r  <= wb_reg_write_nxt;
            wb_rd_r         <= wb_rd_nxt;
            wb_data_r       <= wb_data_nxt;
            err_misalign_r  <= err_misalign_nxt;
            err_illegal_r   <= err_illegal_nxt;
            err_timeout_r   <= err_timeout_nxt;
            pend_rd_r       <= pend_rd_nxt;
            pend_wen_r      <= pend_wen_nxt;
            pend_m2r_r      <= pend_m2r_nxt;
        end
    end

    // ex_ready is held low for the whole reset and rises in the first IDLE cycle.
    assign bus.ex_ready      = rst_n & (state_r == ST_IDLE);
    assign bus.pc_src        = pc_src_r;
    assign bus.branch_target = branch_target_r;
    assign bus.dmem_req      = dmem_req_r;
    assign bus.dmem_we       = dmem_we_r;
    assign bus.dmem_addr     = dmem_addr_r;
    assign bus.dmem_wdata    = dmem_wdata_r;
    assign bus.wb_valid      = wb_valid_r;
    assign bus.wb_reg_write  = wb_reg_write_r;
    assign bus.wb_rd         = wb_rd_r;
    assign bus.wb_data       = wb_data_r;
    assign bus.err_misalign  = err_misalign_r;
    assign bus.err_illegal   = err_illegal_r;
    assign bus.err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Randomised + directed bench for mem_access_stage. The driver issues
// instructions and pushes the expected write-back record (computed from the
// instruction semantics and a memory-contents model) onto a scoreboard; a
// monitor pops and compares on every wb_valid. A responder plays data memory
// with a per-request acknowledge delay and checks each request it sees.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        pc;
        logic [63:0] tgt;
        logic [2:0]  errs;   // {timeout, illegal, misalign}
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        int          delay;  // ack in this request cycle; 0 = never ack
    } req_exp_t;

    wb_exp_t     sb_q[$];
    req_exp_t    rq_q[$];
    logic [63:0] model_mem [logic [63:0]];
    logic [63:0] dev_mem   [logic [63:0]];
    logic        m_mis, m_ill, m_to;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Initial contents of never-written memory locations.
    function automatic logic [63:0] mem_init(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid       = 1'b0;
        bus.ex_result      = {$urandom, $urandom};
        bus.ex_data2       = {$urandom, $urandom};
        bus.ex_zero        = 1'($urandom_range(0, 1));
        bus.ex_branch_addr = {$urandom, $urandom};
        bus.ex_rd          = 5'($urandom_range(0, 31));
        bus.B              = 1'($urandom_range(0, 1));
        bus.BZ             = 1'($urandom_range(0, 1));
        bus.BNZ            = 1'($urandom_range(0, 1));
        bus.MemRead        = 1'($urandom_range(0, 1));
        bus.MemWrite       = 1'($urandom_range(0, 1));
        bus.MemtoReg       = 1'($urandom_range(0, 1));
        bus.RegWrite       = 1'($urandom_range(0, 1));
    endtask

    // Drive one instruction (called at posedge+1) and record what must come out.
    task automatic issue(input logic [63:0] res, input logic [63:0] d2, input logic [63:0] baddr,
                         input logic zero, input logic [4:0] rd,
                         input logic b, input logic bz, input logic bnz,
                         input logic mr, input logic mw, input logic m2r, input logic rw,
                         input int delay);
        int       w;
        int       t0;
        logic     br;
        wb_exp_t  e;
        req_exp_t r;
        w = 0;
        while (!bus.ex_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.ex_ready) begin
            chk("ready_wait", {63'd0, bus.ex_ready}, 64'd1);
            return;
        end
        bus.ex_valid = 1'b1;  bus.ex_result = res;  bus.ex_data2 = d2;
        bus.ex_branch_addr = baddr;  bus.ex_zero = zero;  bus.ex_rd = rd;
        bus.B = b;  bus.BZ = bz;  bus.BNZ = bnz;
        bus.MemRead = mr;  bus.MemWrite = mw;  bus.MemtoReg = m2r;  bus.RegWrite = rw;
        t0 = cyc + 1;   // cycle number in which a latency-1 record is visible
        br = b | bz | bnz;
        e.rd = rd;  e.pc = b | (bz & zero) | (bnz & ~zero);  e.tgt = baddr;
        e.data = res;  e.wen = rw;  e.cyc = t0;
        if (!br && mr && mw) begin
            m_ill = 1'b1;  e.wen = 1'b0;
        end else if (!br && (mr ^ mw)) begin
            if (res[2:0] != 3'd0) begin
                m_mis = 1'b1;  e.wen = 1'b0;
            end else begin
                r.addr = res;  r.we = mw;  r.wdata = d2;  r.delay = delay;
                rq_q.push_back(r);
                if (delay == 0) begin
                    m_to = 1'b1;  e.wen = 1'b0;  e.cyc = t0 + TIMEOUT;
                end else begin
                    e.cyc = t0 + delay;
                    if (mw) begin
                        model_mem[res] = d2;  e.wen = 1'b0;
                    end else if (m2r) begin
                        e.data = model_mem.exists(res) ? model_mem[res] : mem_init(res);
                    end
                end
            end
        end
        e.errs = {m_to, m_ill, m_mis};
        sb_q.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ex_ready"},      {63'd0, bus.ex_ready},     64'd0);
        chk({tag, "_dmem_req"},      {63'd0, bus.dmem_req},     64'd0);
        chk({tag, "_pc_src"},        {63'd0, bus.pc_src},       64'd0);
        chk({tag, "_wb_valid"},      {63'd0, bus.wb_valid},     64'd0);
        chk({tag, "_wb_reg_write"},  {63'd0, bus.wb_reg_write}, 64'd0);
        chk({tag, "_errs"}, {61'd0, bus.err_timeout, bus.err_illegal, bus.err_misalign}, 64'd0);
        chk({tag, "_branch_target"}, bus.branch_target,         64'd0);
        chk({tag, "_dmem_addr"},     bus.dmem_addr,             64'd0);
        chk({tag, "_dmem_wdata"},    bus.dmem_wdata,            64'd0);
        chk({tag, "_wb_rd"},         {59'd0, bus.wb_rd},        64'd0);
        chk({tag, "_wb_data"},       bus.wb_data,               64'd0);
    endtask

    function automatic logic [63:0] pick_addr();
        logic [63:0] a;
        a = 64'h1000 + 64'(8 * $urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) a[2:0] = 3'($urandom_range(1, 7));
        return a;
    endfunction

    // Monitor: compare each write-back record with the scoreboard head.
    always @(negedge clk) begin : monitor
        wb_exp_t e;
        if (rst_n) begin
            if (bus.wb_valid) begin
                if (sb_q.size() == 0) begin
                    chk("wb_unexpected", {63'd0, bus.wb_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wb_rd", {59'd0, bus.wb_rd}, {59'd0, e.rd});
                    chk("wb_reg_write", {63'd0, bus.wb_reg_write}, {63'd0, e.wen});
                    chk("wb_data", bus.wb_data, e.data);
                    chk("pc_src", {63'd0, bus.pc_src}, {63'd0, e.pc});
                    if (e.pc) chk("branch_target", bus.branch_target, e.tgt);
                    chk("err_flags", {61'd0, bus.err_timeout, bus.err_illegal, bus.err_misalign},
                        {61'd0, e.errs});
                end
            end else if (bus.pc_src) begin
                chk("pc_src_spurious", {63'd0, bus.pc_src}, 64'd0);
            end
            if (bus.dmem_req) chk("ready_during_req", {63'd0, bus.ex_ready}, 64'd0);
        end
    end

    // Data-memory responder: acks each request in its scheduled cycle.
    int       rcount = 0;
    req_exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcount = 0;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = 64'd0;
        end else if (bus.dmem_req) begin
            rcount++;
            if (rcount == 1) begin
                if (rq_q.size() > 0) begin
                    cur = rq_q.pop_front();
                end else begin
                    chk("req_unexpected", {63'd0, bus.dmem_req}, 64'd0);
                    cur.addr = 64'd0;  cur.we = 1'b0;  cur.wdata = 64'd0;  cur.delay = 1;
                end
            end
            chk("req_addr", bus.dmem_addr, cur.addr);
            chk("req_we", {63'd0, bus.dmem_we}, {63'd0, cur.we});
            if (cur.we) chk("req_wdata", bus.dmem_wdata, cur.wdata);
            if (cur.delay != 0 && rcount == cur.delay) begin
                bus.dmem_ack = 1'b1;
                if (bus.dmem_we) begin
                    dev_mem[bus.dmem_addr] = bus.dmem_wdata;
                    bus.dmem_rdata = {$urandom, $urandom};
                end else begin
                    bus.dmem_rdata = dev_mem.exists(bus.dmem_addr) ? dev_mem[bus.dmem_addr]
                                                                   : mem_init(bus.dmem_addr);
                end
            end else begin
                bus.dmem_ack = 1'b0;
                bus.dmem_rdata = {$urandom, $urandom};
            end
        end else begin
            if (rcount > 0) chk("req_len", 64'(rcount), 64'((cur.delay == 0) ? TIMEOUT : cur.delay));
            rcount = 0;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = {$urandom, $urandom};
        end
    end

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [63:0] res;
        logic        b, bz, bnz, mr, mw, m2r, rw;
        int          op, dly, w;
        m_mis = 1'b0;  m_ill = 1'b0;  m_to = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {63'd0, bus.ex_ready}, 64'd1);

        // ADD x3 = 0x2A
        issue(64'h2A, 64'd0, 64'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        chk("ready_after_alu", {63'd0, bus.ex_ready}, 64'd1);
        // CBZ taken / not taken
        issue(64'h0, 64'd0, 64'h100, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(64'h5, 64'd0, 64'h100, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        // LDUR 0x40, ack in third request cycle
        model_mem[64'h40] = 64'hDEAD;
        dev_mem[64'h40]   = 64'hDEAD;
        issue(64'h40, 64'd0, 64'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        // STUR misaligned
        issue(64'h43, 64'h1234, 64'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        // LDUR never acknowledged -> timeout, then an ADD must still be accepted
        issue(64'h48, 64'd0, 64'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        issue(64'h77, 64'd0, 64'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        // MemRead & MemWrite together
        issue(64'h50, 64'd0, 64'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        // Store then load back, minimum latency
        issue(64'h60, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        issue(64'h60, 64'd0, 64'd0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            res = {$urandom, $urandom};
            b = 1'b0; bz = 1'b0; bnz = 1'b0; mr = 1'b0; mw = 1'b0; m2r = 1'b0;
            rw = 1'($urandom_range(0, 1));
            case (op)
                3:       b = 1'b1;
                4:       bz = 1'b1;
                5:       bnz = 1'b1;
                6, 7:    begin mr = 1'b1; m2r = 1'b1; res = pick_addr(); end
                8:       begin mw = 1'b1; res = pick_addr(); end
                9:       begin mr = 1'b1; mw = 1'b1; res = pick_addr(); end
                default: rw = 1'($urandom_range(0, 1));
            endcase
            dly = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
            issue(res, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), b, bz, bnz, mr, mw, m2r, rw, dly);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of an access: request dropped, no write-back.
        issue(64'h1000, 64'd0, 64'd0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("req_before_reset", {63'd0, bus.dmem_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        sb_q.delete();
        rq_q.delete();
        m_mis = 1'b0;  m_ill = 1'b0;  m_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_midreset", {63'd0, bus.ex_ready}, 64'd1);
        issue(64'h99, 64'd0, 64'd0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        w = 0;
        while ((sb_q.size() > 0 || rq_q.size() > 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("req_drained", 64'(rq_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
